// File: rtl/bf_sched.sv
// Radix-2 butterfly sequencer: walks every stage of an in-place N-point transform, issues address/twiddle triples.
// Latency: first issue one cycle after start; write-back tags pop combinationally with the butterfly result.
// Backpressure: triple holds while iss_rdy=0; issue throttled to MAX_OUT in flight; each stage drains before the next.

// Generic circular FIFO; head data is visible combinationally whenever not empty.
// Latency: a pushed entry is readable the cycle after the push.
// Backpressure: none internally; the caller must never push when full.
module bf_sched_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign empty    = (cnt == '0);
endmodule

module bf_sched #(
    parameter int LOG_N   = 10,
    parameter int MAX_OUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [1:0]       bf_mode,
    output logic             iss_vld,
    input  logic             iss_rdy,
    output logic [LOG_N-1:0] iss_addr_a,
    output logic [LOG_N-1:0] iss_addr_b,
    output logic [LOG_N-2:0] iss_tw,
    input  logic             bf_o_vld,
    output logic             bf_o_rdy,
    output logic             wr_en,
    output logic [LOG_N-1:0] wr_addr_a,
    output logic [LOG_N-1:0] wr_addr_b,
    output logic             err
);
    localparam int HW = LOG_N - 1;
    localparam int SW = $clog2(LOG_N);
    localparam int CW = $clog2(MAX_OUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [LOG_N-1:0] a;
        logic [LOG_N-1:0] b;
    } tag_t;

    state_t        state, state_nxt;
    logic [SW-1:0] stg;
    logic [HW-1:0] j;
    logic [CW-1:0] outstanding;

    logic          ld_start;
    logic          nxt_stage;
    logic          iss_fire;
    logic          pop;
    logic          fifo_empty;
    logic [SW-1:0] last_stg;
    logic          credit_ok;

    logic [LOG_N-1:0] j_ext, half, mask, addr_a, addr_b;
    logic [SW-1:0]    tw_sh;
    logic [HW-1:0]    tw;
    tag_t             push_tag, head_tag;

    // Inverse modes walk the stages from widest span down to span 1.
    assign last_stg  = bf_mode[0] ? '0 : SW'(LOG_N - 1);
    assign credit_ok = (outstanding < CW'(MAX_OUT));
    assign iss_fire  = iss_vld & iss_rdy;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        iss_vld   = 1'b0;
        done      = 1'b0;
        ld_start  = 1'b0;
        nxt_stage = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    ld_start  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                iss_vld = credit_ok;
                if (credit_ok && iss_rdy && (j == '1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                // Every result of this stage must be written before the next stage reads.
                if (outstanding == '0) begin
                    if (stg == last_stg) begin
                        state_nxt = DONE;
                    end else begin
                        nxt_stage = 1'b1;
                        state_nxt = ISSUE;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bf_mode <= '0;
            stg     <= '0;
            j       <= '0;
        end else if (ld_start) begin
            bf_mode <= mode;
            stg     <= mode[0] ? SW'(LOG_N - 1) : '0;
            j       <= '0;
        end else if (nxt_stage) begin
            stg     <= bf_mode[0] ? stg - SW'(1) : stg + SW'(1);
            j       <= '0;
        end else if (iss_fire) begin
            j       <= j + HW'(1);
        end
    end

    // Group base is j with its low s bits kept and the rest shifted up by one.
    always_comb begin
        j_ext  = {1'b0, j};
        half   = LOG_N'(1) << stg;
        mask   = half - LOG_N'(1);
        addr_a = ((j_ext & ~mask) << 1) | (j_ext & mask);
        addr_b = addr_a | half;
        tw_sh  = SW'(LOG_N - 1) - stg;
        tw     = (j & mask[HW-1:0]) << tw_sh;
    end

    assign iss_addr_a = (state == ISSUE) ? addr_a : '0;
    assign iss_addr_b = (state == ISSUE) ? addr_b : '0;
    assign iss_tw     = (state == ISSUE) ? tw     : '0;

    assign push_tag.a = addr_a;
    assign push_tag.b = addr_b;

    bf_sched_fifo #(
        .W     ($bits(tag_t)),
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (iss_fire),
        .push_dat (push_tag),
        .pop      (pop),
        .head_dat (head_tag),
        .empty    (fifo_empty)
    );

    assign bf_o_rdy  = ~fifo_empty;
    assign pop       = bf_o_vld & ~fifo_empty;
    assign wr_en     = pop;
    assign wr_addr_a = fifo_empty ? '0 : head_tag.a;
    assign wr_addr_b = fifo_empty ? '0 : head_tag.b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({iss_fire, pop})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // A result with no tag waiting means the pipeline and scheduler disagree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          err <= 1'b0;
        else if (bf_o_vld && fifo_empty)  err <= 1'b1;
    end
endmodule

// File: tb/tb_bf_sched.sv
// Bench for bf_sched at LOG_N=3, MAX_OUT=2: table of expected butterflies per stage, scoreboard
// of issue triples and write-back tags, plus sequences for credit, stall, reset and error corners.
module tb_bf_sched;
    localparam int LOG_N   = 3;
    localparam int MAX_OUT = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       mode;
    logic             busy;
    logic             done;
    logic [1:0]       bf_mode;
    logic             iss_vld;
    logic             iss_rdy;
    logic [LOG_N-1:0] iss_addr_a;
    logic [LOG_N-1:0] iss_addr_b;
    logic [LOG_N-2:0] iss_tw;
    logic             bf_o_vld;
    logic             bf_o_rdy;
    logic             wr_en;
    logic [LOG_N-1:0] wr_addr_a;
    logic [LOG_N-1:0] wr_addr_b;
    logic             err;

    logic resp_vld = 1'b0;
    logic poke     = 1'b0;
    assign bf_o_vld = resp_vld | poke;

    always #5 clk = ~clk;

    bf_sched #(.LOG_N(LOG_N), .MAX_OUT(MAX_OUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .busy       (busy),
        .done       (done),
        .bf_mode    (bf_mode),
        .iss_vld    (iss_vld),
        .iss_rdy    (iss_rdy),
        .iss_addr_a (iss_addr_a),
        .iss_addr_b (iss_addr_b),
        .iss_tw     (iss_tw),
        .bf_o_vld   (bf_o_vld),
        .bf_o_rdy   (bf_o_rdy),
        .wr_en      (wr_en),
        .wr_addr_a  (wr_addr_a),
        .wr_addr_b  (wr_addr_b),
        .err        (err)
    );

    typedef struct {int stg; int j; int a; int b; int tw;} vec_t;
    typedef struct {int a; int b; int tw;} iss_t;

    vec_t tbl [12];
    iss_t exp_iss [$];
    int   exp_wa [$];
    int   exp_wb [$];
    int   due_q [$];
    iss_t e;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, out_tb = 0, n_iss = 0, n_wr = 0, done_cnt = 0, cur_lat = 2;
    bit rnd_rdy = 1'b0, prev_stall = 1'b0, prev_done = 1'b0;
    logic [1:0] cur_mode = 2'b00;
    int pa, pb, pt;

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic fill_exp(input logic [1:0] m);
        exp_iss.delete();
        for (int p = 0; p < LOG_N; p++) begin
            int s;
            s = m[0] ? (LOG_N - 1 - p) : p;
            for (int i = 0; i < 12; i++)
                if (tbl[i].stg == s) exp_iss.push_back('{tbl[i].a, tbl[i].b, tbl[i].tw});
        end
    endtask

    // Drive butterfly-side inputs just after the falling edge, sample one unit later.
    always begin
        @(negedge clk);
        #1;
        cyc++;
        iss_rdy  = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        resp_vld = (due_q.size() > 0) && (due_q[0] <= cyc) && !rst;
        #1;
        if (prev_stall) begin
            chk("stall_vld", int'(iss_vld), 1);
            chk("stall_a", int'(iss_addr_a), pa);
            chk("stall_b", int'(iss_addr_b), pb);
            chk("stall_tw", int'(iss_tw), pt);
        end
        prev_stall = iss_vld && !iss_rdy;
        pa = int'(iss_addr_a); pb = int'(iss_addr_b); pt = int'(iss_tw);
        if (wr_en) begin
            n_wr++;
            out_tb--;
            if (exp_wa.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL wr_extra: write-back a=%0d b=%0d with none expected", wr_addr_a, wr_addr_b);
            end else begin
                chk("wr_a", int'(wr_addr_a), exp_wa.pop_front());
                chk("wr_b", int'(wr_addr_b), exp_wb.pop_front());
            end
            if (due_q.size() > 0) void'(due_q.pop_front());
        end
        if (iss_vld && iss_rdy) begin
            n_iss++;
            out_tb++;
            if (exp_iss.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL iss_extra: issue a=%0d b=%0d with none expected", iss_addr_a, iss_addr_b);
            end else begin
                e = exp_iss.pop_front();
                chk("iss_a", int'(iss_addr_a), e.a);
                chk("iss_b", int'(iss_addr_b), e.b);
                chk("iss_tw", int'(iss_tw), e.tw);
                exp_wa.push_back(e.a);
                exp_wb.push_back(e.b);
            end
            due_q.push_back(cyc + cur_lat);
            chk("out_cap", int'(out_tb <= MAX_OUT), 1);
        end
        if (busy) chk("bf_mode", int'(bf_mode), int'(cur_mode));
        if (prev_done) begin
            chk("done_1cyc", int'(done), 0);
            chk("busy_after_done", int'(busy), 0);
        end
        prev_done = done;
        if (done) begin
            done_cnt++;
            chk("done_busy", int'(busy), 1);
            chk("done_all_written", exp_wa.size(), 0);
        end
    end

    task automatic run_xform(input logic [1:0] m, input int lat, input bit rnd, input bit credit);
        int to;
        cur_mode = m; cur_lat = lat; rnd_rdy = rnd;
        done_cnt = 0; n_iss = 0; n_wr = 0;
        fill_exp(m);
        @(negedge clk); mode = m; start = 1'b1;
        @(negedge clk); start = 1'b0; mode = ~m;
        #3;
        chk("first_vld", int'(iss_vld), 1);
        chk("busy_on", int'(busy), 1);
        if (credit) begin
            to = 0;
            while (n_iss < 2 && to < 100) begin @(negedge clk); #3; to++; end
            @(negedge clk); #3;
            chk("credit_stop", int'(iss_vld), 0);
            to = 0;
            while (!wr_en && to < 100) begin @(negedge clk); #3; to++; end
            chk("credit_wr_seen", int'(wr_en), 1);
            @(negedge clk); #3;
            chk("credit_resume", int'(iss_vld), 1);
        end
        to = 0;
        while (done_cnt == 0 && to < 3000) begin @(negedge clk); to++; end
        chk("done_in_time", int'(to < 3000), 1);
        repeat (3) @(negedge clk);
        chk("done_count", done_cnt, 1);
        chk("issue_count", n_iss, 12);
        chk("write_count", n_wr, 12);
        chk("exp_left", exp_iss.size(), 0);
        chk("idle_busy", int'(busy), 0);
        mode = m;
    endtask

    initial begin
        int to;
        tbl[0]  = '{0, 0, 0, 1, 0}; tbl[1]  = '{0, 1, 2, 3, 0};
        tbl[2]  = '{0, 2, 4, 5, 0}; tbl[3]  = '{0, 3, 6, 7, 0};
        tbl[4]  = '{1, 0, 0, 2, 0}; tbl[5]  = '{1, 1, 1, 3, 2};
        tbl[6]  = '{1, 2, 4, 6, 0}; tbl[7]  = '{1, 3, 5, 7, 2};
        tbl[8]  = '{2, 0, 0, 4, 0}; tbl[9]  = '{2, 1, 1, 5, 1};
        tbl[10] = '{2, 2, 2, 6, 2}; tbl[11] = '{2, 3, 3, 7, 3};

        rst = 1'b1; start = 1'b0; mode = 2'b00; iss_rdy = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_iss_vld", int'(iss_vld), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_bf_mode", int'(bf_mode), 0);
        chk("rst_addr_a", int'(iss_addr_a), 0);
        chk("rst_addr_b", int'(iss_addr_b), 0);
        chk("rst_tw", int'(iss_tw), 0);
        chk("rst_bf_o_rdy", int'(bf_o_rdy), 0);
        @(negedge clk); rst = 1'b0;
        #3;
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_wr_addr", int'(wr_addr_a), 0);

        run_xform(2'b00, 2, 1'b0, 1'b0);
        run_xform(2'b11, 2, 1'b0, 1'b0);
        run_xform(2'b01, 10, 1'b0, 1'b1);
        run_xform(2'b10, 2, 1'b1, 1'b0);

        // Start while busy is ignored, then reset lands in stage 1.
        cur_mode = 2'b00; cur_lat = 2; rnd_rdy = 1'b0;
        done_cnt = 0; n_iss = 0; n_wr = 0;
        fill_exp(2'b00);
        @(negedge clk); mode = 2'b00; start = 1'b1;
        @(negedge clk); start = 1'b0;
        to = 0;
        while (n_iss < 2 && to < 100) begin @(negedge clk); to++; end
        start = 1'b1; mode = 2'b11;
        @(negedge clk); start = 1'b0; mode = 2'b00;
        to = 0;
        while (n_iss < 5 && to < 200) begin @(negedge clk); to++; end
        chk("reached_stage1", int'(n_iss >= 5), 1);
        rst = 1'b1;
        exp_iss.delete(); exp_wa.delete(); exp_wb.delete(); due_q.delete();
        out_tb = 0; prev_stall = 1'b0; prev_done = 1'b0; resp_vld = 1'b0;
        #3;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_iss_vld", int'(iss_vld), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_wr_en", int'(wr_en), 0);
        chk("midrst_bf_o_rdy", int'(bf_o_rdy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_no_done", done_cnt, 0);
        run_xform(2'b00, 2, 1'b1, 1'b0);

        // Result with no tag waiting.
        @(negedge clk); poke = 1'b1;
        #3;
        chk("err_wr_en", int'(wr_en), 0);
        chk("err_bf_o_rdy", int'(bf_o_rdy), 0);
        @(negedge clk); poke = 1'b0;
        #3;
        chk("err_set", int'(err), 1);
        repeat (3) @(negedge clk);
        #3;
        chk("err_sticky", int'(err), 1);
        @(negedge clk); rst = 1'b1;
        #3;
        chk("err_cleared", int'(err), 0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
